// File: rtl/sdcard_writeback.sv
// Streams NUM_WORDS 128-bit RAM words to an SD card controller as 512-byte single-block writes,
// low byte of each word first, using a 4-phase byte handshake.
module sdcard_writeback #(
    parameter logic [21:0] NUM_WORDS   = 22'h000400,
    parameter logic [31:0] START_BLOCK = 32'h00000000
) (
    input  logic         clk50,
    input  logic         reset_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  error_code,
    output logic         ram_re,
    output logic [21:0]  ram_address,
    input  logic [127:0] ram_rdata,
    input  logic         ram_rvalid,
    output logic         sd_wr,
    output logic [31:0]  sd_addr,
    output logic [7:0]   sd_data,
    output logic         sd_hndshk_i,
    input  logic         sd_hndshk_o,
    input  logic         sd_busy,
    input  logic [15:0]  sd_error
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_BLK_START = 4'd2;
    localparam logic [3:0] S_FETCH     = 4'd3;
    localparam logic [3:0] S_SEND      = 4'd4;
    localparam logic [3:0] S_ACK       = 4'd5;
    localparam logic [3:0] S_BLK_END   = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERROR     = 4'd8;

    logic [3:0]   state_q, state_d;
    logic [21:0]  word_cnt_q, word_cnt_d;
    logic [3:0]   byte_idx_q, byte_idx_d;
    logic [127:0] shift_q, shift_d;
    logic [15:0]  err_code_q, err_code_d;
    logic [31:0]  sd_addr_q, sd_addr_d;
    logic         busy_q, done_q, error_q, ram_re_q, sd_wr_q, hndshk_q;

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        err_code_d = err_code_q;
        sd_addr_d  = sd_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
                else       state_d = S_IDLE;
            end
            S_INIT: begin
                if (!sd_busy) begin
                    if (sd_error != 16'h0000)        state_d = S_ERROR;
                    else if (NUM_WORDS == 22'd0)     state_d = S_DONE;
                    else                             state_d = S_BLK_START;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_BLK_START: begin
                if (sd_busy) state_d = S_FETCH;
                else         state_d = S_BLK_START;
            end
            S_FETCH: begin
                if (ram_rvalid) begin
                    shift_d    = ram_rdata;
                    byte_idx_d = 4'd0;
                    state_d    = S_SEND;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_SEND: begin
                if (sd_hndshk_o) state_d = S_ACK;
                else             state_d = S_SEND;
            end
            S_ACK: begin
                if (!sd_hndshk_o) begin
                    if (byte_idx_q != 4'd15) begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        shift_d    = {8'h00, shift_q[127:8]};
                        state_d    = S_SEND;
                    end else begin
                        word_cnt_d = word_cnt_q + 22'd1;
                        if (word_cnt_q[4:0] == 5'd31) state_d = S_BLK_END;
                        else                          state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            S_BLK_END: begin
                if (!sd_busy) begin
                    if (sd_error != 16'h0000)           state_d = S_ERROR;
                    else if (word_cnt_q == NUM_WORDS)   state_d = S_DONE;
                    else                                state_d = S_BLK_START;
                end else begin
                    state_d = S_BLK_END;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_ERROR) && (state_q != S_ERROR)) err_code_d = sd_error;
        else                                              err_code_d = err_code_q;

        // Block address is captured once per block so it cannot move while the card is writing
        if ((state_d == S_BLK_START) && (state_q != S_BLK_START))
            sd_addr_d = START_BLOCK + {15'd0, word_cnt_d[21:5]};
        else
            sd_addr_d = sd_addr_q;
    end

    // State, datapath and output registers; outputs decode the next state so they align with state_q
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            word_cnt_q <= 22'd0;
            byte_idx_q <= 4'd0;
            shift_q    <= 128'd0;
            err_code_q <= 16'h0000;
            sd_addr_q  <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ram_re_q   <= 1'b0;
            sd_wr_q    <= 1'b0;
            hndshk_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            err_code_q <= err_code_d;
            sd_addr_q  <= sd_addr_d;
            busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERROR);
            ram_re_q   <= (state_d == S_FETCH);
            sd_wr_q    <= (state_d == S_BLK_START);
            hndshk_q   <= (state_d == S_SEND);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign error_code  = err_code_q;
    assign ram_re      = ram_re_q;
    assign ram_address = word_cnt_q;
    assign sd_wr       = sd_wr_q;
    assign sd_addr     = sd_addr_q;
    assign sd_data     = shift_q[7:0];
    assign sd_hndshk_i = hndshk_q;
endmodule

// File: tb/tb_sdcard_writeback.sv
// Scoreboard bench: RAM and SD controller models check addresses/bytes against queued expectations.
module tb_sdcard_writeback;
    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic         reset_n, start, busy, done, error;
    logic [15:0]  error_code;
    logic         ram_re;
    logic [21:0]  ram_address;
    logic [127:0] ram_rdata;
    logic         ram_rvalid;
    logic         sd_wr;
    logic [31:0]  sd_addr;
    logic [7:0]   sd_data;
    logic         sd_hndshk_i, sd_hndshk_o, sd_busy;
    logic [15:0]  sd_error;

    logic         start0, busy0, done0, error0, ram_re0, sd_wr0, hs0;
    logic [15:0]  error_code0;
    logic [21:0]  ram_address0;
    logic [31:0]  sd_addr0;
    logic [7:0]   sd_data0;

    sdcard_writeback #(.NUM_WORDS(22'd64), .START_BLOCK(32'd5)) dut (
        .clk50(clk50), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .error(error), .error_code(error_code), .ram_re(ram_re), .ram_address(ram_address),
        .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid), .sd_wr(sd_wr), .sd_addr(sd_addr),
        .sd_data(sd_data), .sd_hndshk_i(sd_hndshk_i), .sd_hndshk_o(sd_hndshk_o),
        .sd_busy(sd_busy), .sd_error(sd_error)
    );

    sdcard_writeback #(.NUM_WORDS(22'd0), .START_BLOCK(32'd5)) dut0 (
        .clk50(clk50), .reset_n(reset_n), .start(start0), .busy(busy0), .done(done0),
        .error(error0), .error_code(error_code0), .ram_re(ram_re0), .ram_address(ram_address0),
        .ram_rdata(128'd0), .ram_rvalid(1'b0), .sd_wr(sd_wr0), .sd_addr(sd_addr0),
        .sd_data(sd_data0), .sd_hndshk_i(hs0), .sd_hndshk_o(1'b0),
        .sd_busy(1'b0), .sd_error(16'h0000)
    );

    int n_pass = 0, n_total = 0;
    logic [7:0]  exp_byte[$];
    logic [31:0] exp_blk[$];
    logic [21:0] exp_raddr[$];
    int lat = 1, dly = 0, mode = 0;
    logic [15:0] err_after_blk = 16'h0000;
    int byte_cnt = 0, wr_cnt = 0, stable_err = 0, wr0_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] ram_word(input logic [21:0] k);
        logic [127:0] w;
        if (mode == 0) w = {16{k[7:0]}};
        else           w = 128'h0F0E0D0C0B0A09080706050403020100;
        return w;
    endfunction

    task automatic expect_run(input int nwords, input int nblocks);
        for (int k = 0; k < nwords; k++) begin
            exp_raddr.push_back(22'(k));
            for (int b = 0; b < 16; b++) exp_byte.push_back(mode == 0 ? 8'(k) : 8'(b));
        end
        for (int b = 0; b < nblocks; b++) exp_blk.push_back(32'd5 + 32'(b));
    endtask

    // RAM model: checks each requested address, answers after lat cycles
    initial begin
        logic [21:0] ea;
        ram_rvalid = 1'b0;
        ram_rdata  = 128'd0;
        forever begin
            @(negedge clk50);
            if (reset_n && ram_re) begin
                if (exp_raddr.size() == 0) chk("ram_address_extra", 64'(ram_address), 64'h3FFFFF);
                else begin
                    ea = exp_raddr.pop_front();
                    chk("ram_address", 64'(ram_address), 64'(ea));
                end
                repeat (lat - 1) @(negedge clk50);
                ram_rdata  = ram_word(ram_address);
                ram_rvalid = 1'b1;
                @(negedge clk50);
                ram_rvalid = 1'b0;
            end
        end
    end

    // SD controller model: accepts a block write, acks 512 bytes, then releases busy
    initial begin
        logic [7:0]  d, eb;
        logic [31:0] ea;
        int nb;
        sd_busy = 1'b0;
        sd_hndshk_o = 1'b0;
        forever begin
            @(negedge clk50);
            if (reset_n && sd_wr && !sd_busy) begin
                wr_cnt++;
                if (exp_blk.size() == 0) chk("sd_wr_extra", 64'(sd_addr), 64'hFFFFFFFF);
                else begin
                    ea = exp_blk.pop_front();
                    chk("sd_addr", 64'(sd_addr), 64'(ea));
                end
                sd_busy = 1'b1;
                nb = 0;
                while (nb < 512 && reset_n) begin
                    @(negedge clk50);
                    if (reset_n && sd_hndshk_i && !sd_hndshk_o) begin
                        d = sd_data;
                        for (int i = 0; i < dly; i++) begin
                            @(negedge clk50);
                            if (sd_data !== d || sd_hndshk_i !== 1'b1) stable_err++;
                        end
                        sd_hndshk_o = 1'b1;
                        if (exp_byte.size() == 0) chk("byte_extra", 64'(d), 64'h1FF);
                        else begin
                            eb = exp_byte.pop_front();
                            chk("sd_data", 64'(d), 64'(eb));
                        end
                        nb++;
                        byte_cnt++;
                        for (int i = 0; i < 100 && sd_hndshk_i; i++) @(negedge clk50);
                        sd_hndshk_o = 1'b0;
                    end
                end
                if (reset_n) begin
                    repeat (3) @(negedge clk50);
                    sd_error = err_after_blk;
                end
                sd_busy = 1'b0;
                sd_hndshk_o = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk50);
            if (sd_wr0) wr0_cnt++;
        end
    end

    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_ctl", 64'({busy, done, error, ram_re, sd_wr, sd_hndshk_i, sd_data, error_code}), 64'd0);
        chk("rst_addr", 64'({ram_address, sd_addr}), 64'd0);
        repeat (10) @(negedge clk50);
        exp_byte.delete();
        exp_raddr.delete();
        exp_blk.delete();
        sd_error = 16'h0000;
        err_after_blk = 16'h0000;
        byte_cnt = 0;
        wr_cnt = 0;
        stable_err = 0;
        reset_n = 1'b1;
        @(negedge clk50);
    endtask

    task automatic pulse_start();
        @(negedge clk50) start = 1'b1;
        @(negedge clk50) start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(done || error); i++) @(negedge clk50);
        chk("finished", 64'(done | error), 64'd1);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 20000 && byte_cnt < n; i++) @(negedge clk50);
        chk("reached_byte", 64'(byte_cnt >= n), 64'd1);
    endtask

    task automatic check_end(input logic exp_done, input logic exp_err, input logic [15:0] exp_code,
                             input int exp_wr, input int exp_bytes);
        repeat (2) @(negedge clk50);
        chk("done", 64'(done), 64'(exp_done));
        chk("error", 64'(error), 64'(exp_err));
        chk("error_code", 64'(error_code), 64'(exp_code));
        chk("busy_end", 64'(busy), 64'd0);
        chk("sd_wr_count", 64'(wr_cnt), 64'(exp_wr));
        chk("byte_count", 64'(byte_cnt), 64'(exp_bytes));
        chk("queues_empty", 64'(exp_byte.size() + exp_raddr.size() + exp_blk.size()), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        sd_error = 16'h0000;
        @(negedge clk50);
        do_reset();

        // {16{k}} pattern over two blocks, with an ignored start pulse mid-run
        mode = 0; lat = 1; dly = 0;
        expect_run(64, 2);
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_bytes(300);
        pulse_start();
        wait_end(20000);
        check_end(1'b1, 1'b0, 16'h0000, 2, 1024);

        // constant 0F0E..0100 word, 7-cycle RAM latency
        do_reset();
        mode = 1; lat = 7;
        expect_run(64, 2);
        pulse_start();
        wait_end(20000);
        check_end(1'b1, 1'b0, 16'h0000, 2, 1024);

        // error reported at INIT
        do_reset();
        mode = 0; lat = 1;
        sd_error = 16'h0004;
        pulse_start();
        wait_end(200);
        check_end(1'b0, 1'b1, 16'h0004, 0, 0);

        // slow handshake plus error after block 0
        do_reset();
        dly = 20;
        err_after_blk = 16'h0010;
        expect_run(32, 1);
        pulse_start();
        wait_end(40000);
        check_end(1'b0, 1'b1, 16'h0010, 1, 512);
        chk("data_stable", 64'(stable_err), 64'd0);

        // reset in the middle of block 0, then a full restart
        do_reset();
        dly = 0;
        expect_run(64, 2);
        pulse_start();
        wait_bytes(200);
        do_reset();
        expect_run(64, 2);
        pulse_start();
        wait_end(20000);
        check_end(1'b1, 1'b0, 16'h0000, 2, 1024);

        // NUM_WORDS = 0
        pulse_start0();
        for (int i = 0; i < 20 && !done0; i++) @(negedge clk50);
        chk("nw0_done", 64'(done0), 64'd1);
        chk("nw0_error", 64'(error0), 64'd0);
        pulse_start0();
        repeat (5) @(negedge clk50);
        chk("nw0_state_after_start", 64'({busy0, done0}), 64'b01);
        chk("nw0_no_sd_wr", 64'(wr0_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic pulse_start0();
        @(negedge clk50) start0 = 1'b1;
        @(negedge clk50) start0 = 1'b0;
    endtask
endmodule
